pmc_shift_engine: RTL and testbench
===================================

Name: pmc_shift_engine

Overview:
- Parametrised serial shift engine for the pixel matrix controller.
- Serialises NUM_CH parallel data words onto per-channel matrix data lines, generates the matrix shift clock (clkSh), and deserialises the matrix return lines into parallel capture words, all in one full-duplex transfer.
- Sits between the PMC register file (dout/din banks) and the matrix pads, and replaces bit-banging of clkSh by the PMC coprocessor.
- Adds what the fixed 16x32 register scheme lacks: configurable channel count, word width and clkSh divider, programmable transfer length, selectable bit order, and abort.

Parameters:
NUM_CH, 16, number of parallel matrix channels
DATA_W, 32, bits per channel word; maximum transfer length
CLK_DIV, 2, clk cycles per clkSh phase (low and high each); must be >= 1
LEN_W, $clog2(DATA_W)+1, width of shift_len

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin transfer; sampled in IDLE only
abort  in  1  terminate transfer, return to IDLE
lsb_first  in  1  bit order, latched at start: 1 = bit 0 first, 0 = bit N-1 first
shift_len  in  LEN_W  bits per channel N, latched at start; 0 or >DATA_W means DATA_W
dout_data  in  NUM_CH*DATA_W  words to shift out; channel c occupies [c*DATA_W +: DATA_W]; latched at start
din_data  out  NUM_CH*DATA_W  captured words, same packing
matrix_dout  out  NUM_CH  serial data to matrix, one bit per channel
matrix_din  in  NUM_CH  serial data from matrix
clk_sh  out  1  matrix shift clock
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer completion

Interface: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset: state IDLE. din_data, matrix_dout, clk_sh, busy and done are all 0. Internal shift and capture registers are cleared.
- States: IDLE, LO, HI, DONE. All outputs are registered.
- IDLE:
  - clk_sh = 0, busy = 0.
  - matrix_dout holds the last driven value (0 after reset).
  - When start = 1 at an edge: latch N, lsb_first and the dout words; clear the capture registers; set bit counter = 0; go to LO.
- LO (CLK_DIV cycles):
  - clk_sh = 0, busy = 1.
  - matrix_dout[c] = current transmit bit of channel c. This is valid from the first LO cycle and stable through the end of HI.
- HI (CLK_DIV cycles):
  - clk_sh = 1.
  - At the edge ending the last HI cycle, sample matrix_din into the capture registers.
  - If bit counter = N-1, go to DONE. Otherwise increment the counter and go to LO.
- Bit mapping for transfer bit k, k = 0..N-1:
  - MSB-first: transmit word[N-1-k]; captured bit goes to capture[N-1-k].
  - LSB-first: transmit word[k]; captured bit goes to capture[k].
  - Capture bits [DATA_W-1:N] are 0.
- DONE (1 cycle):
  - done = 1, busy = 1, clk_sh = 0.
  - din_data is loaded from the capture registers on entry, so it is valid in the same cycle done is high.
  - Next state is IDLE.
- din_data changes only on entry to DONE. It holds across later IDLE periods and aborted transfers.
- Latency: start sampled at edge 0 gives first LO cycle = cycle 1 and done in cycle 1 + 2*CLK_DIV*N. busy is high for 2*CLK_DIV*N + 1 cycles.
- start while not in IDLE is ignored and never queued. start in the DONE cycle is ignored. start is accepted the cycle after DONE.
- abort = 1 in LO, HI or DONE: next state IDLE, clk_sh = 0, busy = 0, done not pulsed, din_data unchanged. abort in IDLE has no effect.
- abort and start high together in IDLE: abort wins and the transfer does not start.
- rst mid-transfer: behaves as reset (din_data cleared to 0), no done pulse.
- Counters: phase counter $clog2(CLK_DIV) bits (minimum 1); bit counter LEN_W bits. Neither wraps within a transfer.

Test Plan:
- Reset: hold rst 2 cycles mid-transfer -> all outputs 0, state IDLE, no done.
- Loopback, default parameters: matrix_din = matrix_dout, lsb_first = 0, shift_len = 32, channel c word = 0xA5A50F00 + c -> done in cycle 129 after start, din_data equals dout_data; clk_sh toggles 64 times with period 4 cycles.
- Short LSB-first: shift_len = 4, lsb_first = 1, ch0 word = 0xFFFFFFF6, matrix_din tied to 1 -> matrix_dout[0] sequence 0,1,1,0; din_data ch0 = 0x0000000F; done in cycle 17.
- Length 0 and overflow: shift_len = 0, then shift_len = 40 -> each behaves as N = 32 (done in cycle 129).
- start during busy: pulse start in cycle 10 of a transfer -> ignored, exactly one done pulse; start in the cycle after DONE is accepted.
- Abort: with din_data = 0x12345678, assert abort in HI of bit 5 -> IDLE next cycle, busy = 0, clk_sh = 0, no done, din_data still 0x12345678; abort together with start in IDLE -> no transfer.

Source files
------------

// File: rtl/pmc_shift_engine.sv
// rtl/pmc_shift_engine.sv - full-duplex serial shift engine driving the matrix shift clock
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start, abort  begin transfer (IDLE only) / terminate transfer
//   lsb_first     bit order latched at start (1 = bit 0 first)
//   shift_len     bits per channel, latched at start (0 or > DATA_W means DATA_W)
//   dout_data     NUM_CH packed words to shift out, channel c at [c*DATA_W +: DATA_W]
//   din_data      NUM_CH packed captured words, updated only on entry to DONE
//   matrix_dout   serial data to matrix, one bit per channel
//   matrix_din    serial data from matrix, sampled at the end of each HI phase
//   clk_sh        matrix shift clock
//   busy, done    transfer in progress / one-cycle completion pulse
module pmc_shift_engine #(
  parameter int NUM_CH  = 16,
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = $clog2(DATA_W) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     lsb_first,
  input  logic [LEN_W-1:0]         shift_len,
  input  logic [NUM_CH*DATA_W-1:0] dout_data,
  output logic [NUM_CH*DATA_W-1:0] din_data,
  output logic [NUM_CH-1:0]        matrix_dout,
  input  logic [NUM_CH-1:0]        matrix_din,
  output logic                     clk_sh,
  output logic                     busy,
  output logic                     done
);

  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                     state, state_n;
  logic [PH_W-1:0]            ph, ph_n;
  logic [LEN_W-1:0]           cnt, cnt_n, len_q, len_n;
  logic                       lsb_q, lsb_n;
  logic [NUM_CH*DATA_W-1:0]   tx_q, tx_n, cap_q, cap_n, din_n;
  logic [NUM_CH-1:0]          mdout_n;
  logic                       clk_sh_n, busy_n, done_n;
  logic [LEN_W-1:0]           start_len;

  // Word bit position addressed by transfer bit k.
  function automatic logic [LEN_W-1:0] bit_pos(input logic [LEN_W-1:0] n,
                                               input logic lsb,
                                               input logic [LEN_W-1:0] k);
    bit_pos = lsb ? k : (n - ONE - k);
  endfunction

  function automatic logic [NUM_CH-1:0] tx_bits(input logic [NUM_CH*DATA_W-1:0] words,
                                                input logic [LEN_W-1:0] pos);
    logic [DATA_W-1:0] w;
    tx_bits = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w          = words[c*DATA_W +: DATA_W];
      tx_bits[c] = w[pos[IDX_W-1:0]];
    end
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] cap_insert(input logic [NUM_CH*DATA_W-1:0] cap,
                                                          input logic [NUM_CH-1:0] bits,
                                                          input logic [LEN_W-1:0] pos);
    logic [DATA_W-1:0] w;
    cap_insert = cap;
    for (int c = 0; c < NUM_CH; c++) begin
      w                              = cap[c*DATA_W +: DATA_W];
      w[pos[IDX_W-1:0]]              = bits[c];
      cap_insert[c*DATA_W +: DATA_W] = w;
    end
  endfunction

  assign start_len = (shift_len == '0 || shift_len > FULL_LEN) ? FULL_LEN : shift_len;

  // Outputs are computed for the next state and registered with it, so
  // every output is a flop and matches the state it is observed in.
  always_comb begin
    state_n  = state;
    ph_n     = ph;
    cnt_n    = cnt;
    len_n    = len_q;
    lsb_n    = lsb_q;
    tx_n     = tx_q;
    cap_n    = cap_q;
    din_n    = din_data;
    mdout_n  = matrix_dout;
    clk_sh_n = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = LO;
          ph_n    = '0;
          cnt_n   = '0;
          len_n   = start_len;
          lsb_n   = lsb_first;
          tx_n    = dout_data;
          cap_n   = '0;
          busy_n  = 1'b1;
          // First transmit bit straight from the inputs so it is valid in the first LO cycle.
          mdout_n = tx_bits(dout_data, bit_pos(start_len, lsb_first, '0));
        end
      end
      LO: begin
        busy_n = 1'b1;
        if (ph == PH_LAST) begin
          state_n  = HI;
          ph_n     = '0;
          clk_sh_n = 1'b1;
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      HI: begin
        busy_n   = 1'b1;
        clk_sh_n = 1'b1;
        if (ph == PH_LAST) begin
          ph_n     = '0;
          clk_sh_n = 1'b0;
          cap_n    = cap_insert(cap_q, matrix_din, bit_pos(len_q, lsb_q, cnt));
          if (cnt == len_q - ONE) begin
            state_n = DONE;
            done_n  = 1'b1;
            din_n   = cap_n;
          end else begin
            state_n = LO;
            cnt_n   = cnt + ONE;
            mdout_n = tx_bits(tx_q, bit_pos(len_q, lsb_q, cnt + ONE));
          end
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (abort && state != IDLE) begin
      state_n  = IDLE;
      clk_sh_n = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      din_n    = din_data;
      mdout_n  = matrix_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ph          <= '0;
      cnt         <= '0;
      len_q       <= '0;
      lsb_q       <= 1'b0;
      tx_q        <= '0;
      cap_q       <= '0;
      din_data    <= '0;
      matrix_dout <= '0;
      clk_sh      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      ph          <= ph_n;
      cnt         <= cnt_n;
      len_q       <= len_n;
      lsb_q       <= lsb_n;
      tx_q        <= tx_n;
      cap_q       <= cap_n;
      din_data    <= din_n;
      matrix_dout <= mdout_n;
      clk_sh      <= clk_sh_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_pmc_shift_engine.sv
// tb/tb_pmc_shift_engine.sv - directed self-checking bench for pmc_shift_engine
module tb_pmc_shift_engine;

  localparam int NUM_CH  = 16;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 6;
  localparam int BIT_CYC = 4;
  localparam int W       = NUM_CH * DATA_W;

  logic             clk = 1'b0;
  logic             rst, start, abort, lsb_first;
  logic [LEN_W-1:0] shift_len;
  logic [W-1:0]     dout_data, din_data;
  logic [NUM_CH-1:0] matrix_dout, matrix_din;
  logic             clk_sh, busy, done;
  logic             loop_en;
  logic [NUM_CH-1:0] tie_val;

  int errors = 0;
  int checks = 0;
  int cyc;

  assign matrix_din = loop_en ? matrix_dout : tie_val;

  always #5 clk = ~clk;

  pmc_shift_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lsb_first(lsb_first),
    .shift_len(shift_len), .dout_data(dout_data), .din_data(din_data),
    .matrix_dout(matrix_dout), .matrix_din(matrix_din), .clk_sh(clk_sh),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
  endtask

  function automatic logic [W-1:0] fill(input logic [31:0] base, input bit add_ch);
    logic [W-1:0] v;
    for (int c = 0; c < NUM_CH; c++)
      v[c*DATA_W +: DATA_W] = base + (add_ch ? c : 0);
    return v;
  endfunction

  // Runs from cycle 1 until done; start is pulsed in cycle inj (0 = never).
  task automatic run_to_done(input int inj, output int done_cyc, output int toggles,
                             output int busy_cnt, output logic [31:0] seq0);
    logic prev;
    prev     = 1'b0;
    done_cyc = -1;
    toggles  = 0;
    busy_cnt = 0;
    seq0     = '0;
    while (cyc <= 400) begin
      if (clk_sh != prev) toggles++;
      prev = clk_sh;
      if (busy) busy_cnt++;
      if (((cyc - 1) % BIT_CYC) == 0 && !done) seq0 = {seq0[30:0], matrix_dout[0]};
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc == inj);
      step();
    end
    start = 1'b0;
  endtask

  int dc, tg, bc, quiet;
  logic [31:0] sq;
  logic [W-1:0] exp_v;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; lsb_first = 1'b0;
    shift_len = 6'd32; dout_data = '0; loop_en = 1'b1; tie_val = '0;
    cyc = 0;
    step(); step();
    rst = 1'b0;
    check("reset_din", din_data, '0);
    check("reset_outs", {matrix_dout, clk_sh, busy, done}, '0);

    // Loopback, MSB first, full length
    dout_data = fill(32'hA5A50F00, 1'b1);
    go();
    run_to_done(0, dc, tg, bc, sq);
    check("loop_done_cyc", dc, 129);
    check("loop_din", din_data, dout_data);
    check("loop_toggles", tg, 64);
    check("loop_busy_cycles", bc, 129);
    check("loop_ch0_serial", sq, 32'hA5A50F00);

    // Short LSB-first with matrix_din tied high
    step();
    loop_en = 1'b0; tie_val = '1; lsb_first = 1'b1; shift_len = 6'd4;
    dout_data = '0;
    dout_data[31:0] = 32'hFFFFFFF6;
    go();
    run_to_done(0, dc, tg, bc, sq);
    check("lsb_done_cyc", dc, 17);
    check("lsb_ch0_seq", sq[3:0], 4'b0110);
    check("lsb_din", din_data, fill(32'h0000000F, 1'b0));

    // Length 0 and overflow both mean 32
    loop_en = 1'b1; lsb_first = 1'b0;
    step();
    shift_len = 6'd0;
    dout_data = fill(32'h3C00C300, 1'b1);
    go();
    run_to_done(0, dc, tg, bc, sq);
    check("len0_done_cyc", dc, 129);
    check("len0_din", din_data, dout_data);
    step();
    shift_len = 6'd40;
    dout_data = fill(32'h81000001, 1'b1);
    go();
    run_to_done(0, dc, tg, bc, sq);
    check("len40_done_cyc", dc, 129);
    check("len40_din", din_data, dout_data);

    // start during busy ignored; start in DONE ignored; start after DONE accepted
    step();
    shift_len = 6'd32;
    dout_data = fill(32'h00FF00FF, 1'b1);
    go();
    run_to_done(10, dc, tg, bc, sq);
    check("busy_start_done_cyc", dc, 129);
    start = 1'b1;
    step();
    check("done_cycle_start_ignored", busy, 1'b0);
    step();
    start = 1'b0;
    cyc = 1;
    check("after_done_start_busy", busy, 1'b1);
    run_to_done(0, dc, tg, bc, sq);
    check("after_done_xfer_cyc", dc, 129);
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) quiet++;
    end
    check("no_extra_done", quiet, 0);

    // Abort: establish din = 0x12345678 on every channel first
    dout_data = fill(32'h12345678, 1'b0);
    go();
    run_to_done(0, dc, tg, bc, sq);
    check("abort_setup_din", din_data, fill(32'h12345678, 1'b0));
    step();
    dout_data = fill(32'hDEADBEEF, 1'b0);
    go();
    while (cyc < 23) step();
    check("abort_in_hi_bit5", clk_sh, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_outs", {clk_sh, busy, done}, 3'b000);
    check("abort_din_kept", din_data, fill(32'h12345678, 1'b0));
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) quiet++;
    end
    check("abort_no_done", quiet, 0);

    // abort with start in IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", {busy, clk_sh}, 2'b00);
    step();
    check("abort_start_idle2", busy, 1'b0);

    // Reset mid-transfer
    dout_data = fill(32'h55AA55AA, 1'b1);
    go();
    while (cyc < 30) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("midrst_din", din_data, '0);
    check("midrst_outs", {matrix_dout, clk_sh, busy, done}, '0);
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) quiet++;
    end
    check("midrst_no_done", quiet, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
